// File: rtl/tournament_sampler_if.sv
// Start/busy control, fitness-memory port, comparator port and parent-pair handshake.
// The sampler uses the master modport; memory, comparator and consumer use the slave modport.
interface tournament_sampler_if #(
  parameter int unsigned FITNESS_WIDTH = 27,
  parameter int unsigned IDX_WIDTH     = 4
);
  logic                     i_start;
  logic                     o_busy;
  logic [IDX_WIDTH-1:0]     o_fit_addr;
  logic [FITNESS_WIDTH-1:0] i_fit_data;
  logic [FITNESS_WIDTH-1:0] o_sel_fitness1;
  logic [FITNESS_WIDTH-1:0] o_sel_fitness2;
  logic                     o_sel_enable;
  logic                     i_sel_selected;
  logic [IDX_WIDTH-1:0]     o_parent_a;
  logic [IDX_WIDTH-1:0]     o_parent_b;
  logic                     o_pair_valid;
  logic                     i_pair_ready;

  modport master (
    input  i_start, i_fit_data, i_sel_selected, i_pair_ready,
    output o_busy, o_fit_addr, o_sel_fitness1, o_sel_fitness2, o_sel_enable,
           o_parent_a, o_parent_b, o_pair_valid
  );

  modport slave (
    output i_start, i_fit_data, i_sel_selected, i_pair_ready,
    input  o_busy, o_fit_addr, o_sel_fitness1, o_sel_fitness2, o_sel_enable,
           o_parent_a, o_parent_b, o_pair_valid
  );
endinterface

// File: rtl/tournament_sampler.sv
// Runs two LFSR-drawn binary tournaments and returns the winning parent pair.
// Pair valid 15 cycles after start (+1 per redraw); the pair is held in DONE until pair_ready.
module tournament_sampler #(
  parameter int unsigned FITNESS_WIDTH = 27,
  parameter int unsigned POP_SIZE      = 16,
  parameter int unsigned IDX_WIDTH     = $clog2(POP_SIZE),
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  tournament_sampler_if.master bus
);

  localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  typedef enum logic [3:0] {
    S_IDLE, S_DRAW_A, S_DRAW_B, S_FETCH_A, S_FETCH_B,
    S_CAPTURE_B, S_COMPARE, S_RESULT, S_DONE
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [15:0]              r_lfsr;
  logic [15:0]              w_lfsr_nxt;
  logic                     r_round;
  logic [IDX_WIDTH-1:0]     r_idx1;
  logic [IDX_WIDTH-1:0]     r_idx2;
  logic [FITNESS_WIDTH-1:0] r_f1;
  logic [FITNESS_WIDTH-1:0] r_sel_f1;
  logic [FITNESS_WIDTH-1:0] r_sel_f2;
  logic [IDX_WIDTH-1:0]     r_parent_a;
  logic [IDX_WIDTH-1:0]     r_parent_b;
  logic [IDX_WIDTH-1:0]     w_draw;
  logic [IDX_WIDTH-1:0]     w_winner;
  logic [IDX_WIDTH-1:0]     w_fit_addr;
  logic                     w_lfsr_adv;
  logic                     w_busy;
  logic                     w_sel_en;
  logic                     w_pair_vld;

  assign w_draw     = r_lfsr[IDX_WIDTH-1:0] & IDX_WIDTH'(POP_SIZE - 1);
  assign w_lfsr_nxt = r_lfsr[0] ? ((r_lfsr >> 1) ^ 16'hB400) : (r_lfsr >> 1);
  assign w_winner   = bus.i_sel_selected ? r_idx2 : r_idx1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Control outputs decode straight from the state so reset clears them without a clock.
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b1;
    w_fit_addr  = '0;
    w_sel_en    = 1'b0;
    w_pair_vld  = 1'b0;
    w_lfsr_adv  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (bus.i_start) w_state_nxt = S_DRAW_A;
      end
      S_DRAW_A: begin
        w_lfsr_adv  = 1'b1;
        w_state_nxt = S_DRAW_B;
      end
      S_DRAW_B: begin
        w_lfsr_adv = 1'b1;
        if (w_draw != r_idx1) w_state_nxt = S_FETCH_A;
      end
      S_FETCH_A: begin
        w_fit_addr  = r_idx1;
        w_state_nxt = S_FETCH_B;
      end
      S_FETCH_B: begin
        w_fit_addr  = r_idx2;
        w_state_nxt = S_CAPTURE_B;
      end
      S_CAPTURE_B: w_state_nxt = S_COMPARE;
      S_COMPARE: begin
        w_sel_en    = 1'b1;
        w_state_nxt = S_RESULT;
      end
      S_RESULT: w_state_nxt = r_round ? S_DONE : S_DRAW_A;
      S_DONE: begin
        w_pair_vld = 1'b1;
        if (bus.i_pair_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_lfsr     <= SEED_EFF;
      r_round    <= 1'b0;
      r_idx1     <= '0;
      r_idx2     <= '0;
      r_f1       <= '0;
      r_sel_f1   <= '0;
      r_sel_f2   <= '0;
      r_parent_a <= '0;
      r_parent_b <= '0;
    end else begin
      if (w_lfsr_adv) r_lfsr <= w_lfsr_nxt;
      case (r_state)
        S_IDLE:      if (bus.i_start) r_round <= 1'b0;
        S_DRAW_A:    r_idx1 <= w_draw;
        S_DRAW_B:    if (w_draw != r_idx1) r_idx2 <= w_draw;
        S_FETCH_B:   r_f1 <= bus.i_fit_data;
        // Comparator operands change only here, so they stay stable between COMPAREs.
        S_CAPTURE_B: begin
          r_sel_f1 <= r_f1;
          r_sel_f2 <= bus.i_fit_data;
        end
        S_RESULT: begin
          if (!r_round) begin
            r_parent_a <= w_winner;
            r_round    <= 1'b1;
          end else begin
            r_parent_b <= w_winner;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_busy         = w_busy;
  assign bus.o_fit_addr     = w_fit_addr;
  assign bus.o_sel_fitness1 = r_sel_f1;
  assign bus.o_sel_fitness2 = r_sel_f2;
  assign bus.o_sel_enable   = w_sel_en;
  assign bus.o_parent_a     = r_parent_a;
  assign bus.o_parent_b     = r_parent_b;
  assign bus.o_pair_valid   = w_pair_vld;

endmodule

// File: tb/tb_tournament_sampler.sv
// Bench for tournament_sampler: POP_SIZE 16 and POP_SIZE 2 instances against a golden LFSR model.
module tb_tournament_sampler;
  localparam int FW = 27;
  typedef logic [FW-1:0] fit_t;

  typedef struct packed {
    logic [1:0][3:0] i1;
    logic [1:0][3:0] i2;
    logic [1:0][3:0] w;
    logic [7:0]      redraws;
  } exp_t;

  typedef struct {
    fit_t       f0;
    fit_t       f1;
    bit         tie;
    logic [3:0] a;
    logic [3:0] b;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tournament_sampler_if #(.FITNESS_WIDTH(FW), .IDX_WIDTH(4)) b16 ();
  tournament_sampler_if #(.FITNESS_WIDTH(FW), .IDX_WIDTH(1)) b2 ();

  tournament_sampler #(.FITNESS_WIDTH(FW), .POP_SIZE(16), .IDX_WIDTH(4), .LFSR_SEED(16'hACE1))
    u16 (.i_clk(clk), .i_rst(rst), .bus(b16));
  tournament_sampler #(.FITNESS_WIDTH(FW), .POP_SIZE(2), .IDX_WIDTH(1), .LFSR_SEED(16'hACE1))
    u2 (.i_clk(clk), .i_rst(rst), .bus(b2));

  // Synchronous-read fitness memories and registered comparators (lower wins, tie -> contestant 2).
  fit_t mem16 [16];
  fit_t mem2  [2];
  always @(posedge clk) begin
    b16.i_fit_data <= mem16[b16.o_fit_addr];
    b2.i_fit_data  <= mem2[b2.o_fit_addr];
    if (b16.o_sel_enable) b16.i_sel_selected <= (b16.o_sel_fitness2 <= b16.o_sel_fitness1);
    if (b2.o_sel_enable)  b2.i_sel_selected  <= (b2.o_sel_fitness2 <= b2.o_sel_fitness1);
  end

  int   en16 = 0;
  int   en2  = 0;
  fit_t l1_16[$], l2_16[$], l1_2[$], l2_2[$];
  always @(negedge clk) begin
    if (b16.o_sel_enable) begin
      en16 = en16 + 1;
      l1_16.push_back(b16.o_sel_fitness1);
      l2_16.push_back(b16.o_sel_fitness2);
    end
    if (b2.o_sel_enable) begin
      en2 = en2 + 1;
      l1_2.push_back(b2.o_sel_fitness1);
      l2_2.push_back(b2.o_sel_fitness2);
    end
  end

  int n_chk  = 0;
  int n_pass = 0;
  task automatic chk(input string name, input longint act, input longint req);
    n_chk = n_chk + 1;
    if (act == req) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  logic [15:0] m16, m2;
  exp_t sb[$];

  function automatic logic [15:0] adv(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  function automatic fit_t memrd(input bit p2, input logic [3:0] a);
    return p2 ? mem2[a[0]] : mem16[a];
  endfunction

  task automatic model_pair(input bit p2, output exp_t e);
    logic [15:0] s;
    logic [3:0]  msk, i1, i2;
    s = p2 ? m2 : m16;
    msk = p2 ? 4'h1 : 4'hF;
    e = '0;
    for (int t = 0; t < 2; t++) begin
      i1 = s[3:0] & msk; s = adv(s);
      i2 = s[3:0] & msk; s = adv(s);
      while (i2 == i1) begin
        e.redraws = e.redraws + 8'd1;
        i2 = s[3:0] & msk; s = adv(s);
      end
      e.i1[t] = i1;
      e.i2[t] = i2;
      e.w[t]  = (memrd(p2, i2) <= memrd(p2, i1)) ? i2 : i1;
    end
    if (p2) m2 = s; else m16 = s;
  endtask

  function automatic bit vld(input bit p2);
    return p2 ? b2.o_pair_valid : b16.o_pair_valid;
  endfunction
  function automatic bit bsy(input bit p2);
    return p2 ? b2.o_busy : b16.o_busy;
  endfunction
  function automatic logic [3:0] par(input bit p2, input bit which);
    if (p2) return which ? {3'b0, b2.o_parent_b} : {3'b0, b2.o_parent_a};
    return which ? b16.o_parent_b : b16.o_parent_a;
  endfunction
  function automatic longint lg(input bit p2, input bit which, input int idx);
    if (p2) begin
      if (idx >= l1_2.size()) return -1;
      return which ? longint'(l2_2[idx]) : longint'(l1_2[idx]);
    end
    if (idx >= l1_16.size()) return -1;
    return which ? longint'(l2_16[idx]) : longint'(l1_16[idx]);
  endfunction
  task automatic set_start(input bit p2, input logic v);
    if (p2) b2.i_start = v; else b16.i_start = v;
  endtask

  // One request: model pushes the expectation, the DUT's pair pops and checks it.
  task automatic do_pair(input bit p2, input bit hold, output logic [3:0] pa,
                         output logic [3:0] pb, output exp_t g);
    exp_t e;
    int   n, en0, lg0;
    bit   got;
    model_pair(p2, e);
    sb.push_back(e);
    en0 = p2 ? en2 : en16;
    lg0 = p2 ? l1_2.size() : l1_16.size();
    @(negedge clk); set_start(p2, 1'b1);
    @(posedge clk); n = 1;
    @(negedge clk); set_start(p2, 1'b0);
    got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      if (vld(p2)) got = 1'b1;
      else begin
        @(posedge clk); @(negedge clk); n = n + 1;
      end
    end
    g = sb.pop_front();
    chk("pair_valid_seen", got, 1);
    chk("latency", n, 15 + int'(g.redraws));
    chk("parent_a", par(p2, 1'b0), g.w[0]);
    chk("parent_b", par(p2, 1'b1), g.w[1]);
    chk("sel_enable_pulses", (p2 ? en2 : en16) - en0, 2);
    for (int t = 0; t < 2; t++) begin
      chk("sel_fitness1", lg(p2, 1'b0, lg0 + t), memrd(p2, g.i1[t]));
      chk("sel_fitness2", lg(p2, 1'b1, lg0 + t), memrd(p2, g.i2[t]));
      if (!p2) chk("contestants_distinct", lg(p2, 1'b0, lg0 + t) != lg(p2, 1'b1, lg0 + t), 1);
    end
    pa = par(p2, 1'b0);
    pb = par(p2, 1'b1);
    if (!hold) begin
      @(posedge clk); @(negedge clk);
      chk("idle_after_transfer", {vld(p2), bsy(p2)}, 0);
    end
  endtask

  function automatic logic [3:0] hi(input logic [3:0] x, input logic [3:0] y);
    return (x > y) ? x : y;
  endfunction

  initial begin
    logic [3:0] pa, pb;
    exp_t       g;
    bit         stable, got;
    vec_t       vt [5];

    vt[0] = '{f0: 27'd5,          f1: 27'd9,          tie: 1'b0, a: 4'd0, b: 4'd0};
    vt[1] = '{f0: 27'd9,          f1: 27'd5,          tie: 1'b0, a: 4'd1, b: 4'd1};
    vt[2] = '{f0: 27'h7FF_FFFF,   f1: 27'd0,          tie: 1'b0, a: 4'd1, b: 4'd1};
    vt[3] = '{f0: 27'd0,          f1: 27'h7FF_FFFF,   tie: 1'b0, a: 4'd0, b: 4'd0};
    vt[4] = '{f0: 27'd7,          f1: 27'd7,          tie: 1'b1, a: 4'd0, b: 4'd0};

    rst = 1'b1;
    b16.i_start = 1'b0; b2.i_start = 1'b0;
    b16.i_pair_ready = 1'b1; b2.i_pair_ready = 1'b1;
    for (int i = 0; i < 16; i++) mem16[i] = fit_t'(100 - i);
    mem2[0] = 27'd5; mem2[1] = 27'd9;
    m16 = 16'hACE1; m2 = 16'hACE1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",       b16.o_busy, 0);
    chk("rst_fit_addr",   b16.o_fit_addr, 0);
    chk("rst_sel_enable", b16.o_sel_enable, 0);
    chk("rst_sel_fit1",   b16.o_sel_fitness1, 0);
    chk("rst_sel_fit2",   b16.o_sel_fitness2, 0);
    chk("rst_parents",    {b16.o_parent_a, b16.o_parent_b}, 0);
    chk("rst_pair_valid", b16.o_pair_valid, 0);
    chk("rst_pop2_outs",  {b2.o_busy, b2.o_pair_valid, b2.o_sel_enable, b2.o_parent_a, b2.o_parent_b}, 0);
    rst = 1'b0;

    // POP_SIZE 16, fitness 100-i: the higher index always wins.
    for (int r = 0; r < 3; r++) begin
      do_pair(1'b0, 1'b0, pa, pb, g);
      chk("parent_a_higher_idx", pa, hi(g.i1[0], g.i2[0]));
      chk("parent_b_higher_idx", pb, hi(g.i1[1], g.i2[1]));
    end

    // POP_SIZE 2 vectors: clear winners, width extremes, tie.
    for (int v = 0; v < 5; v++) begin
      mem2[0] = vt[v].f0;
      mem2[1] = vt[v].f1;
      do_pair(1'b1, 1'b0, pa, pb, g);
      if (vt[v].tie) begin
        chk("tie_parent_a_is_idx2", pa, g.i2[0]);
        chk("tie_parent_b_is_idx2", pb, g.i2[1]);
      end else begin
        chk("vec_parent_a", pa, vt[v].a);
        chk("vec_parent_b", pb, vt[v].b);
      end
    end

    // Backpressure: pair held 20 cycles, start pulsed in DONE must be ignored.
    b16.i_pair_ready = 1'b0;
    do_pair(1'b0, 1'b1, pa, pb, g);
    stable = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (k == 5) b16.i_start = 1'b1;
      if (k == 7) b16.i_start = 1'b0;
      @(posedge clk); @(negedge clk);
      if (!(b16.o_pair_valid && b16.o_busy && b16.o_parent_a == pa && b16.o_parent_b == pb))
        stable = 1'b0;
    end
    chk("backpressure_stable", stable, 1);
    b16.i_pair_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("release_to_idle", {b16.o_pair_valid, b16.o_busy}, 0);
    repeat (3) begin @(posedge clk); end
    @(negedge clk);
    chk("done_start_ignored", b16.o_busy, 0);
    do_pair(1'b0, 1'b0, pa, pb, g);

    // Reset while holding a pair in DONE.
    b16.i_pair_ready = 1'b0;
    do_pair(1'b0, 1'b1, pa, pb, g);
    rst = 1'b1;
    #1;
    chk("rst_done_pair_valid", b16.o_pair_valid, 0);
    chk("rst_done_busy",       b16.o_busy, 0);
    chk("rst_done_sel_enable", b16.o_sel_enable, 0);
    chk("rst_done_parent_a",   b16.o_parent_a, 0);
    @(negedge clk);
    rst = 1'b0;
    b16.i_pair_ready = 1'b1;
    m16 = 16'hACE1; m2 = 16'hACE1;

    // Reset during COMPARE drops sel_enable without a clock edge.
    @(negedge clk); b16.i_start = 1'b1;
    @(posedge clk); @(negedge clk); b16.i_start = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      if (b16.o_sel_enable) got = 1'b1;
      else @(negedge clk);
    end
    chk("compare_reached", got, 1);
    rst = 1'b1;
    #1;
    chk("rst_compare_sel_enable", b16.o_sel_enable, 0);
    chk("rst_compare_busy",       b16.o_busy, 0);
    @(negedge clk);
    rst = 1'b0;
    m16 = 16'hACE1; m2 = 16'hACE1;

    // First pairs after reset follow the freshly seeded model.
    do_pair(1'b0, 1'b0, pa, pb, g);
    mem2[0] = 27'd5; mem2[1] = 27'd9;
    do_pair(1'b1, 1'b0, pa, pb, g);
    chk("post_rst_pop2_a", pa, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/tournament_sampler.md
# tournament_sampler

Upstream feeder for the `selection` comparator in the GA datapath. On each request it runs two binary tournaments, each between two distinct individuals drawn pseudo-randomly from the population. It reads both contestants' fitness from the population fitness memory, drives the comparator, and collects its verdict. The result is a pair of parent indices handed to the crossover stage through a valid/ready handshake.

## Interface
- `FITNESS_WIDTH`, 27, width of one fitness value; must match the comparator.
- `POP_SIZE`, 16, population size; power of two, ≥ 2.
- `IDX_WIDTH`, $clog2(POP_SIZE), individual index width.
- `LFSR_SEED`, 16'hACE1, LFSR reset value; a zero seed is replaced by 16'h0001.
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request one parent pair; sampled only in IDLE.
- `busy`  out  1  high in every state except IDLE.
- `fit_addr`  out  IDX_WIDTH  fitness memory read address; memory is synchronous-read, data valid one cycle after the address.
- `fit_data`  in  FITNESS_WIDTH  fitness memory read data.
- `sel_fitness1`  out  FITNESS_WIDTH  contestant 1 fitness to comparator.
- `sel_fitness2`  out  FITNESS_WIDTH  contestant 2 fitness to comparator.
- `sel_enable`  out  1  comparator enable, one-cycle pulse.
- `sel_selected`  in  1  comparator verdict, registered: 0 = contestant 1 wins, 1 = contestant 2 wins.
- `parent_a`, `parent_b`  out  IDX_WIDTH  tournament winners.
- `pair_valid`  out  1  parents valid.
- `pair_ready`  in  1  consumer accepts the pair.

## Operation
- **LFSR:** 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400). It advances exactly once in each DRAW_A and DRAW_B cycle and holds in all other states. A draw is `lfsr[IDX_WIDTH-1:0]`, taken before the advance.
- **States:** IDLE, DRAW_A, DRAW_B, FETCH_A, FETCH_B, CAPTURE_B, COMPARE, RESULT, DONE. A `round` bit selects parent A (0) or parent B (1).
- **IDLE:** on `start` → DRAW_A with round = 0.
- **DRAW_A:** idx1 ← draw → DRAW_B.
- **DRAW_B:**
  - If draw == idx1, stay in DRAW_B and redraw next cycle; contestants are always distinct.
  - Otherwise idx2 ← draw → FETCH_A.
- **FETCH_A:** `fit_addr` = idx1 → FETCH_B.
- **FETCH_B:** `fit_addr` = idx2; f1 ← `fit_data` → CAPTURE_B.
- **CAPTURE_B:** f2 ← `fit_data` → COMPARE.
- **COMPARE:** `sel_enable` = 1; `sel_fitness1`/`sel_fitness2` = f1/f2, held stable from this cycle until the next COMPARE → RESULT.
- **RESULT:**
  - winner = `sel_selected` ? idx2 : idx1.
  - round 0: `parent_a` ← winner; round ← 1 → DRAW_A.
  - round 1: `parent_b` ← winner → DONE.
- **DONE:** `pair_valid` = 1, with parents held stable. If `pair_ready` is high, the transfer completes and the state returns to IDLE; `pair_valid` is low the following cycle.
- **Winner rule:** lower fitness wins (minimisation). On a tie the comparator picks contestant 2.
- **Parents:** `parent_a` == `parent_b` is legal, since the two tournaments are independent.
- **Unused address:** `fit_addr` is 0 in states that do not read.

## Timing
- **Reset values:** state IDLE, lfsr = LFSR_SEED, round 0, and every output at 0 (`busy`, `fit_addr`, `sel_*`, `parent_a`, `parent_b`, `pair_valid`).
- **Reset mid-operation:** asserting `rst` in any state aborts immediately (asynchronous). `pair_valid` and `sel_enable` drop without waiting for a clock.
- **Latency:** `start` sampled in cycle 0 puts the block in DRAW_A in cycle 1. Each tournament takes 7 cycles; each DRAW_B redraw adds 1. With no redraws, `pair_valid` is first high in cycle 15.
- **Pulse widths:** `sel_enable` is high for exactly one cycle per tournament, i.e. twice per pair.
- **Ignored start:** `start` is ignored in every state except IDLE, including DONE. In DONE, `pair_valid` stays high indefinitely while `pair_ready` is low.
- **Back-to-back pairs:** the earliest next request is `start` held high, accepted in the IDLE cycle after DONE.

## Test plan
- **Reset:** assert `rst` in DONE → `pair_valid`, `busy` and `sel_enable` are 0 immediately. First pair after release matches the golden LFSR model seeded with 16'hACE1.
- **Clear winner:** POP_SIZE = 2, fitness[0] = 5, fitness[1] = 9 → both tournaments compare {0,1}; `parent_a` = `parent_b` = 0.
- **Tie:** POP_SIZE = 2, fitness[0] = fitness[1] = 7 → each winner equals that tournament's idx2.
- **Latency and redraw:** POP_SIZE = 16, fitness[i] = 100 − i, `start` pulsed once → `pair_valid` at cycle 15 + (redraw count from model).
  - Each parent is the higher-index contestant.
  - Exactly two `sel_enable` pulses.
  - idx1 ≠ idx2 in both tournaments.
- **Backpressure:** hold `pair_ready` = 0 for 20 cycles and pulse `start` during DONE → parents and `pair_valid` stay stable and the extra `start` is ignored. Release → IDLE next cycle.
- **Width extremes:** fitness values 2^27 − 1 vs 0 → 0 wins; full-width values reach `sel_fitness1`/`sel_fitness2` unchanged.
